hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS pipeline. It sits beside the decode stage and detects load-use hazards between the instruction in IF/ID and a load in ID/EX. It also applies branch-taken flushes and freezes the whole pipeline while data memory is busy. Its outputs drive PC write-enable, IF/ID write/flush, ID/EX bubble/flush, EX/MEM flush and the downstream register hold, and it keeps saturating event counters.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal range 1..3
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous active-high reset
instr_IFID  in  32  instruction currently held in IF/ID
mem_IDEX  in  3  ID/EX memory control; bit 1 = MemRead
instr20_16_IDEX  in  5  rt field of the instruction in ID/EX
branch_taken_EXMEM  in  1  branch resolved taken in MEM (PCSrc)
dmem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  zero ID/EX control fields (insert bubble)
idex_flush  out  1  clear ID/EX
exmem_flush  out  1  clear EX/MEM control
pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents
state  out  2  current FSM state (debug)
stall_cnt  out  CNT_W  cycles with idex_bubble=1, saturating
flush_cnt  out  CNT_W  cycles with branch flush asserted, saturating
freeze_cnt  out  CNT_W  cycles with pipe_hold=1, saturating

Behaviour:
- States: RUN=0, LU_STALL=1, FREEZE=2. Registers: state, ret_state, rem (2 bits), three counters.
- Outputs are combinational (Mealy) from the effective state and current inputs. Effective state is ret_state when state=FREEZE and dmem_busy=0; otherwise it is state.
- Load-use detection (lu): mem_IDEX[1] && instr20_16_IDEX!=0 && (instr20_16_IDEX==instr_IFID[25:21] || (uses_rt(op) && instr20_16_IDEX==instr_IFID[20:16])).
- uses_rt(op) is true for op 0x00, 0x04, 0x05 and 0x2B.
- Priority within a cycle: rst > dmem_busy > branch_taken_EXMEM > LU_STALL continuation > lu.
- rst=1: outputs pc_write=0, ifid_write=0, ifid_flush=idex_flush=exmem_flush=1, idex_bubble=0, pipe_hold=0. Next state RUN, ret_state RUN, rem 0, counters 0. Reset mid-stall or mid-freeze aborts it.
- Default (RUN, no event): pc_write=1, ifid_write=1, every other output 0.
- dmem_busy=1 in any state:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1, no flush, no bubble.
  - If state!=FREEZE, ret_state<=state. Next state FREEZE. rem holds.
  - A pending branch_taken is ignored this cycle; it stays asserted by the held EX/MEM.
- branch_taken (not busy):
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=idex_flush=exmem_flush=1, idex_bubble=0.
  - Next state RUN, rem<=0; this aborts any load-use stall.
- Effective LU_STALL (not busy, no branch):
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - rem<=rem-1. When rem==1, next state is RUN.
- Effective RUN with lu (not busy, no branch):
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - If LOAD_STALL_CYCLES>1: next LU_STALL, rem<=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- Leaving FREEZE (dmem_busy=0): the cycle is evaluated as the effective state, and the next state follows that state's rules.
- Counters increment by 1 on each cycle their output condition holds and saturate at all-ones. Latency 0: hazard response occurs in the same cycle as detection.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State encodings RUN/LU_STALL/FREEZE.
  - Opcode constants OP_RTYPE=0x00, OP_BEQ=0x04, OP_BNE=0x05, OP_SW=0x2B, OP_LW=0x23.
  - MEMREAD_BIT=1.
  - Function uses_rt.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated three times.

Test Plan:
- lw in EX (mem_IDEX=3'b010, rt=2), instr_IFID=0x00441820 (add $3,$2,$4), LOAD_STALL_CYCLES=1 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle with mem_IDEX=0: normal. stall_cnt=1.
- LOAD_STALL_CYCLES=2, lw rt=2, instr_IFID=0xACA20004 (sw $2,4($5)) -> 2 consecutive bubble cycles, state 0->1->0, stall_cnt=2.
- No false stall: lw rt=7 with instr_IFID=0x20A70001 (addi $7,$5,1) -> no stall. lw rt=0 with add using $0 -> no stall.
- Branch during LU_STALL (LOAD_STALL_CYCLES=3, branch_taken pulse in 2nd bubble cycle) -> all three flushes=1, pc_write=1, next state RUN, flush_cnt=1, stall_cnt=2.
- dmem_busy high for 4 cycles during LU_STALL with rem=2 -> pipe_hold=1 for 4 cycles, freeze_cnt=4. After release, 2 more bubble cycles, then RUN.
- rst asserted mid-FREEZE -> next cycle state=0, all counters 0. During rst: flushes=1, pc_write=0. Also preload counters to saturation and confirm they hold at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_ctrl_pkg
// Description : Shared state encodings, opcode constants and decode helper
//               for the pipeline sequencing controller.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam int MEMREAD_BIT = 1;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that increments on inc and sticks at all-ones.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, branch flush and memory-busy freeze control
//               for a 5-stage MIPS pipeline, with saturating event counters.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_IFID,
    input  logic [2:0]       mem_IDEX,
    input  logic [4:0]       instr20_16_IDEX,
    input  logic             branch_taken_EXMEM,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam logic [1:0] C_REM_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    logic [1:0] rem_q, rem_d;

    state_e     w_eff_state;
    logic       w_lu;
    logic       w_flush_inc;
    logic       w_unused;

    // On the cycle memory releases, behave as the state that was frozen.
    assign w_eff_state = ((state_q == FREEZE) && !dmem_busy) ? ret_q : state_q;

    // Load in ID/EX writing a register the IF/ID instruction reads.
    assign w_lu = mem_IDEX[MEMREAD_BIT] && (instr20_16_IDEX != 5'd0) &&
                  ((instr20_16_IDEX == instr_IFID[25:21]) ||
                   (uses_rt(instr_IFID[31:26]) && (instr20_16_IDEX == instr_IFID[20:16])));

    assign w_flush_inc = branch_taken_EXMEM && !dmem_busy;
    assign w_unused    = ^{mem_IDEX[2], mem_IDEX[0], instr_IFID[15:0]};

    // Prioritised next-state and Mealy output decode.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = RUN;
        ret_d       = ret_q;
        rem_d       = rem_q;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            ret_d       = RUN;
            rem_d       = 2'd0;
        end else if (dmem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_d    = FREEZE;
            if (state_q != FREEZE) begin
                ret_d = state_q;
            end
        end else if (branch_taken_EXMEM) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            rem_d       = 2'd0;
        end else if (w_eff_state == LU_STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            rem_d       = rem_q - 2'd1;
            state_d     = (rem_q == 2'd1) ? RUN : LU_STALL;
        end else if (w_lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = LU_STALL;
                rem_d   = C_REM_INIT;
            end
        end
    end

    // Controller state registers; reset values come from the decode above.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        ret_q   <= ret_d;
        rem_q   <= rem_d;
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (idex_bubble),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pipe_hold),
        .count (freeze_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench; three controllers (1, 2 and 3 load-use
//               bubbles) share stimulus and are compared to a reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_IFID;
    logic [2:0]  mem_IDEX;
    logic [4:0]  rt_IDEX;
    logic        br;
    logic        busy;

    logic        pw[3], iw[3], ifl[3], ib[3], idf[3], exf[3], ph[3];
    logic [1:0]  st[3];
    logic [15:0] sc[3], fcn[3], zc[3];

    int checks = 0;
    int errors = 0;

    // Reference model: pending bubbles and frozen flag per instance.
    int m_bub[3];
    bit m_frz[3];
    bit m_known[3];
    int m_sc[3], m_fc[3], m_zc[3];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .instr_IFID(instr_IFID), .mem_IDEX(mem_IDEX),
        .instr20_16_IDEX(rt_IDEX), .branch_taken_EXMEM(br), .dmem_busy(busy),
        .pc_write(pw[0]), .ifid_write(iw[0]), .ifid_flush(ifl[0]), .idex_bubble(ib[0]),
        .idex_flush(idf[0]), .exmem_flush(exf[0]), .pipe_hold(ph[0]), .state(st[0]),
        .stall_cnt(sc[0]), .flush_cnt(fcn[0]), .freeze_cnt(zc[0]));

    hazard_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .instr_IFID(instr_IFID), .mem_IDEX(mem_IDEX),
        .instr20_16_IDEX(rt_IDEX), .branch_taken_EXMEM(br), .dmem_busy(busy),
        .pc_write(pw[1]), .ifid_write(iw[1]), .ifid_flush(ifl[1]), .idex_bubble(ib[1]),
        .idex_flush(idf[1]), .exmem_flush(exf[1]), .pipe_hold(ph[1]), .state(st[1]),
        .stall_cnt(sc[1]), .flush_cnt(fcn[1]), .freeze_cnt(zc[1]));

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .instr_IFID(instr_IFID), .mem_IDEX(mem_IDEX),
        .instr20_16_IDEX(rt_IDEX), .branch_taken_EXMEM(br), .dmem_busy(busy),
        .pc_write(pw[2]), .ifid_write(iw[2]), .ifid_flush(ifl[2]), .idex_bubble(ib[2]),
        .idex_flush(idf[2]), .exmem_flush(exf[2]), .pipe_hold(ph[2]), .state(st[2]),
        .stall_cnt(sc[2]), .flush_cnt(fcn[2]), .freeze_cnt(zc[2]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load-use rule evaluated straight from the instruction fields.
    function automatic bit ref_lu(input logic [31:0] ins, input logic [2:0] mem, input logic [4:0] rt);
        int  op;
        bit  reads_rt;
        op       = int'(ins[31:26]);
        reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
        return mem[1] && (rt != 0) && ((rt == ins[25:21]) || (reads_rt && (rt == ins[20:16])));
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    // Drive one cycle, check every instance at the falling edge, then advance the model.
    task automatic cycle(input logic r, input logic [31:0] ins, input logic [2:0] mem,
                         input logic [4:0] rt, input logic b, input logic bz);
        bit e_pw, e_iw, e_fl, e_bb, e_ph, lu;
        rst = r; instr_IFID = ins; mem_IDEX = mem; rt_IDEX = rt; br = b; busy = bz;
        @(negedge clk);
        lu = ref_lu(ins, mem, rt);
        for (int i = 0; i < 3; i++) begin
            e_pw = 1; e_iw = 1; e_fl = 0; e_bb = 0; e_ph = 0;
            if (r) begin
                e_pw = 0; e_iw = 0; e_fl = 1;
            end else if (bz) begin
                e_pw = 0; e_iw = 0; e_ph = 1;
            end else if (b) begin
                e_fl = 1;
            end else if (m_bub[i] > 0 || lu) begin
                e_pw = 0; e_iw = 0; e_bb = 1;
            end
            chk($sformatf("u%0d_pc_write", i), {15'd0, pw[i]}, {15'd0, e_pw});
            chk($sformatf("u%0d_ifid_write", i), {15'd0, iw[i]}, {15'd0, e_iw});
            chk($sformatf("u%0d_ifid_flush", i), {15'd0, ifl[i]}, {15'd0, e_fl});
            chk($sformatf("u%0d_idex_flush", i), {15'd0, idf[i]}, {15'd0, e_fl});
            chk($sformatf("u%0d_exmem_flush", i), {15'd0, exf[i]}, {15'd0, e_fl});
            chk($sformatf("u%0d_idex_bubble", i), {15'd0, ib[i]}, {15'd0, e_bb});
            chk($sformatf("u%0d_pipe_hold", i), {15'd0, ph[i]}, {15'd0, e_ph});
            if (m_known[i]) begin
                chk($sformatf("u%0d_state", i), {14'd0, st[i]},
                    m_frz[i] ? 16'd2 : (m_bub[i] > 0 ? 16'd1 : 16'd0));
                chk($sformatf("u%0d_stall_cnt", i), sc[i], 16'(m_sc[i]));
                chk($sformatf("u%0d_flush_cnt", i), fcn[i], 16'(m_fc[i]));
                chk($sformatf("u%0d_freeze_cnt", i), zc[i], 16'(m_zc[i]));
            end
            if (r) begin
                m_known[i] = 1; m_bub[i] = 0; m_frz[i] = 0;
                m_sc[i] = 0; m_fc[i] = 0; m_zc[i] = 0;
            end else if (bz) begin
                m_frz[i] = 1; m_zc[i] = sat_inc(m_zc[i]);
            end else if (b) begin
                m_frz[i] = 0; m_bub[i] = 0; m_fc[i] = sat_inc(m_fc[i]);
            end else if (m_bub[i] > 0) begin
                m_frz[i] = 0; m_bub[i]--; m_sc[i] = sat_inc(m_sc[i]);
            end else if (lu) begin
                m_frz[i] = 0; m_bub[i] = i; m_sc[i] = sat_inc(m_sc[i]);
            end else begin
                m_frz[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h0044_1820;
    localparam logic [31:0] I_SW   = 32'hACA2_0004;
    localparam logic [31:0] I_ADDI = 32'h20A7_0001;
    localparam logic [31:0] I_ADD0 = 32'h0000_1820;

    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        for (int i = 0; i < 3; i++) begin
            m_known[i] = 0; m_bub[i] = 0; m_frz[i] = 0;
            m_sc[i] = 0; m_fc[i] = 0; m_zc[i] = 0;
        end
        rst = 1; instr_IFID = '0; mem_IDEX = '0; rt_IDEX = '0; br = 0; busy = 0;
        @(posedge clk); #1;

        // Reset state and single-bubble load-use with add.
        cycle(1, I_ADD, 3'b000, 5'd0, 0, 0);
        cycle(0, I_ADD, 3'b010, 5'd2, 0, 0);
        cycle(0, I_ADD, 3'b000, 5'd2, 0, 0);
        chk("plan_lu1_stall_cnt", sc[0], 16'd1);

        // Two-bubble hazard with sw reading rt.
        cycle(1, I_ADD, 3'b000, 5'd0, 0, 0);
        cycle(0, I_SW, 3'b010, 5'd2, 0, 0);
        cycle(0, I_SW, 3'b000, 5'd2, 0, 0);
        cycle(0, I_SW, 3'b000, 5'd2, 0, 0);
        chk("plan_lu2_stall_cnt", sc[1], 16'd2);
        chk("plan_lu2_state", {14'd0, st[1]}, 16'd0);

        // No false stall: addi writes rt, and a load to $0.
        cycle(1, I_ADD, 3'b000, 5'd0, 0, 0);
        cycle(0, I_ADDI, 3'b010, 5'd7, 0, 0);
        cycle(0, I_ADD0, 3'b010, 5'd0, 0, 0);
        chk("plan_nostall_u3", sc[2], 16'd0);

        // Branch taken cutting a three-bubble stall short.
        cycle(1, I_ADD, 3'b000, 5'd0, 0, 0);
        cycle(0, I_ADD, 3'b010, 5'd2, 0, 0);
        cycle(0, I_ADD, 3'b000, 5'd2, 0, 0);
        cycle(0, I_ADD, 3'b000, 5'd2, 1, 0);
        chk("plan_br_flush_cnt", fcn[2], 16'd1);
        chk("plan_br_stall_cnt", sc[2], 16'd2);
        chk("plan_br_state", {14'd0, st[2]}, 16'd0);

        // Memory busy freezing a stall, then resuming the remaining bubbles.
        cycle(1, I_ADD, 3'b000, 5'd0, 0, 0);
        cycle(0, I_ADD, 3'b010, 5'd2, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, I_ADD, 3'b000, 5'd2, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, I_ADD, 3'b000, 5'd2, 0, 0);
        chk("plan_frz_freeze_cnt", zc[2], 16'd4);
        chk("plan_frz_stall_cnt", sc[2], 16'd3);

        // Reset while frozen.
        cycle(0, I_ADD, 3'b000, 5'd2, 0, 1);
        cycle(0, I_ADD, 3'b000, 5'd2, 0, 1);
        cycle(1, I_ADD, 3'b000, 5'd2, 0, 1);
        chk("plan_rst_state", {14'd0, st[2]}, 16'd0);
        chk("plan_rst_freeze_cnt", zc[2], 16'd0);

        // Randomized traffic with field values biased to collide.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h04;
                2: op = 6'h05;
                3: op = 6'h2B;
                4: op = 6'h23;
                default: op = 6'h08;
            endcase
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            cycle(($urandom_range(0, 59) == 0), ins, 3'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        // Saturation of the freeze counter.
        cycle(1, I_ADD, 3'b000, 5'd0, 0, 0);
        for (int k = 0; k < 65540; k++) cycle(0, I_ADD, 3'b000, 5'd0, 0, 1);
        chk("plan_sat_freeze_cnt", zc[0], 16'hFFFF);
        cycle(0, I_ADD, 3'b000, 5'd0, 0, 1);
        chk("plan_sat_hold", zc[1], 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
